// File: rtl/pla_cube_eval.sv
// pla_cube_eval
//   Programmable sum-of-products evaluator. A cube table of N_CUBES entries
//   is written at runtime. Each accepted input vector is checked against one
//   cube per clock. The OR of the output masks of every hit cube is returned
//   as a registered N_OUT-bit result over a valid/ready handshake.
//
//   A cube hits when it is enabled and agrees with x on every care bit:
//      en && ((x ^ val) & care) == 0
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset; also aborts an evaluation
//   cfg_we     cube table write strobe (honoured only in IDLE)
//   cfg_addr   cube index to write; indices >= N_CUBES are ignored
//   cfg_data   {en, omask[N_OUT-1:0], care[N_IN-1:0], val[N_IN-1:0]}
//   cfg_ready  table writable (IDLE)
//   in_valid   input vector valid
//   in_ready   vector accepted (IDLE and no table write this cycle)
//   x          input vector
//   out_valid  result valid, held until out_ready
//   out_ready  consumer accepts the result
//   y          result; keeps its last value after the handshake
//
// Optional build macro
//   PLA_EARLY_EXIT_EN  when defined, the scan stops as soon as the
//                      accumulated result is all ones. Latency then varies
//                      from 1 to N_CUBES clocks, and the result is unchanged.
//
// State | meaning
// ------+------------------------------------------------------------
// IDLE  | table writable, waiting for an input vector
// EVAL  | scanning the cube table, one cube per clock
// DONE  | result presented, waiting for out_ready

module pla_cube_eval #(
    parameter int N_IN    = 14,
    parameter int N_OUT   = 1,
    parameter int N_CUBES = 16,
    parameter int AW      = (N_CUBES > 1) ? $clog2(N_CUBES) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_we,
    input  logic [AW-1:0]         cfg_addr,
    input  logic [N_OUT+2*N_IN:0] cfg_data,
    output logic                  cfg_ready,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [N_IN-1:0]       x,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [N_OUT-1:0]      y
);

    localparam int EW = 1 + N_OUT + 2 * N_IN;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EVAL = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [AW-1:0] LAST_IDX = AW'(N_CUBES - 1);

    logic [1:0]       state_q, state_d;
    logic [EW-1:0]    table_q [N_CUBES];
    logic [EW-1:0]    table_d [N_CUBES];
    logic [N_IN-1:0]  x_lat_q, x_lat_d;
    logic [AW-1:0]    idx_q, idx_d;
    logic [N_OUT-1:0] acc_q, acc_d;
    logic [N_OUT-1:0] y_q, y_d;
    logic             out_valid_q, out_valid_d;

    logic [EW-1:0]    cube;
    logic             cube_en;
    logic [N_OUT-1:0] cube_omask;
    logic [N_IN-1:0]  cube_care;
    logic [N_IN-1:0]  cube_val;
    logic             cube_hit;
    logic [N_OUT-1:0] acc_next;
    logic             eval_last;
    logic             eval_done;
    logic [31:0]      addr_ext;
    logic             wr_ok;

    assign cube       = table_q[idx_q];
    assign cube_val   = cube[N_IN-1:0];
    assign cube_care  = cube[2*N_IN-1:N_IN];
    assign cube_omask = cube[2*N_IN+N_OUT-1:2*N_IN];
    assign cube_en    = cube[EW-1];

    assign cube_hit  = cube_en && (((x_lat_q ^ cube_val) & cube_care) == '0);
    assign acc_next  = acc_q | (cube_hit ? cube_omask : '0);
    assign eval_last = (idx_q == LAST_IDX);

`ifdef PLA_EARLY_EXIT_EN
    // Once every output bit is set, no remaining cube can change the result.
    assign eval_done = eval_last || (&acc_next);
`else
    assign eval_done = eval_last;
`endif

    // Compare at 32 bits so that a power-of-two table does not produce a
    // constant comparison.
    assign addr_ext = 32'(cfg_addr);
    assign wr_ok    = addr_ext < 32'(N_CUBES);

    assign cfg_ready = (state_q == ST_IDLE);
    assign in_ready  = (state_q == ST_IDLE) && !cfg_we;
    assign out_valid = out_valid_q;
    assign y         = y_q;

    always_comb begin
        state_d     = state_q;
        table_d     = table_q;
        x_lat_d     = x_lat_q;
        idx_d       = idx_q;
        acc_d       = acc_q;
        y_d         = y_q;
        out_valid_d = out_valid_q;

        case (state_q)
            ST_IDLE: begin
                // A table write takes priority, and the vector waits a cycle.
                if (cfg_we) begin
                    if (wr_ok) begin
                        table_d[cfg_addr] = cfg_data;
                    end
                end else if (in_valid) begin
                    x_lat_d = x;
                    acc_d   = '0;
                    idx_d   = '0;
                    state_d = ST_EVAL;
                end
            end
            ST_EVAL: begin
                acc_d = acc_next;
                if (eval_done) begin
                    y_d         = acc_next;
                    out_valid_d = 1'b1;
                    state_d     = ST_DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            x_lat_q     <= '0;
            idx_q       <= '0;
            acc_q       <= '0;
            y_q         <= '0;
            out_valid_q <= 1'b0;
            for (int i = 0; i < N_CUBES; i++) begin
                table_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            x_lat_q     <= x_lat_d;
            idx_q       <= idx_d;
            acc_q       <= acc_d;
            y_q         <= y_d;
            out_valid_q <= out_valid_d;
            for (int i = 0; i < N_CUBES; i++) begin
                table_q[i] <= table_d[i];
            end
        end
    end

endmodule

// File: tb/tb_pla_cube_eval.sv
module tb_pla_cube_eval;

    localparam int N_IN    = 14;
    localparam int N_OUT   = 2;
    localparam int N_CUBES = 16;
    localparam int AW      = 4;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  cfg_we = 1'b0;
    logic [AW-1:0]         cfg_addr = '0;
    logic [N_OUT+2*N_IN:0] cfg_data = '0;
    logic                  cfg_ready;
    logic                  in_valid = 1'b0;
    logic                  in_ready;
    logic [N_IN-1:0]       x = '0;
    logic                  out_valid;
    logic                  out_ready = 1'b0;
    logic [N_OUT-1:0]      y;

    int n_checks = 0;
    int n_fail   = 0;

    pla_cube_eval #(
        .N_IN   (N_IN),
        .N_OUT  (N_OUT),
        .N_CUBES(N_CUBES),
        .AW     (AW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cfg_we   (cfg_we),
        .cfg_addr (cfg_addr),
        .cfg_data (cfg_data),
        .cfg_ready(cfg_ready),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .x        (x),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .y        (y)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit        en;
        bit [1:0]  om;
        bit [13:0] care;
        bit [13:0] val;
    } cube_t;

    typedef struct {
        logic [13:0] x;
        logic [1:0]  y;
    } vec_t;

    cube_t mdl [N_CUBES];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: OR of the masks of every enabled cube that agrees with xv on
    // its care bits. The latency is the number of scanned cubes.
    task automatic model(input logic [13:0] xv, output logic [1:0] ey, output int lat);
        ey  = '0;
        lat = N_CUBES;
        for (int k = 0; k < N_CUBES; k++) begin
            if (mdl[k].en && (((xv ^ mdl[k].val) & mdl[k].care) == 14'h0))
                ey |= mdl[k].om;
`ifdef PLA_EARLY_EXIT_EN
            if (ey == 2'b11 && lat == N_CUBES) lat = k + 1;
`endif
        end
    endtask

    task automatic write_cube(input int a, input bit en, input bit [1:0] om,
                              input bit [13:0] care, input bit [13:0] val);
        cfg_we   = 1'b1;
        cfg_addr = AW'(a);
        cfg_data = {en, om, care, val};
        step();
        cfg_we = 1'b0;
        if (a < N_CUBES) begin
            mdl[a].en   = en;
            mdl[a].om   = om;
            mdl[a].care = care;
            mdl[a].val  = val;
        end
    endtask

    task automatic eval_vec(input logic [13:0] xv, input logic [1:0] ey, input int elat,
                            input bit hold_ready, input string tag);
        int cnt;
        in_valid  = 1'b1;
        x         = xv;
        out_ready = hold_ready;
        #1;
        chk({tag, " in_ready"}, 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        cnt = 0;
        while (!out_valid && cnt < 40) begin
            step();
            cnt++;
        end
        chk({tag, " latency"}, 32'(cnt), 32'(elat));
        chk({tag, " y"}, 32'(y), 32'(ey));
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk({tag, " out_valid clear"}, 32'(out_valid), 32'd0);
        chk({tag, " y held"}, 32'(y), 32'(ey));
    endtask

    task automatic eval_model(input logic [13:0] xv, input bit hold_ready, input string tag);
        logic [1:0] ey;
        int         lat;
        model(xv, ey, lat);
        eval_vec(xv, ey, lat, hold_ready, tag);
    endtask

    vec_t va [4];
    vec_t vb [2];

    initial begin
        logic [1:0] ey;
        int         lat;
        int         cnt;
        bit         seen;

        for (int i = 0; i < N_CUBES; i++) mdl[i] = '{1'b0, 2'b00, 14'h0, 14'h0};

        va[0] = '{14'h3F00, 2'b01};
        va[1] = '{14'h3E00, 2'b00};
        va[2] = '{14'h3FFF, 2'b01};
        va[3] = '{14'h00FF, 2'b00};
        vb[0] = '{14'h0001, 2'b11};
        vb[1] = '{14'h0000, 2'b01};

        // reset
        repeat (3) step();
        rst = 1'b0;
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset y", 32'(y), 32'd0);
        chk("reset cfg_ready", 32'(cfg_ready), 32'd1);
        chk("reset in_ready", 32'(in_ready), 32'd1);

        // empty table
        eval_vec(14'h3FFF, 2'b00, N_CUBES, 1'b0, "empty");

        // single cube on x8..x13
        write_cube(5, 1'b1, 2'b01, 14'h3F00, 14'h3F00);
        for (int i = 0; i < 4; i++) begin
            model(va[i].x, ey, lat);
            eval_vec(va[i].x, va[i].y, lat, 1'b0, $sformatf("vecA%0d", i));
        end

        // two output bits from the first and last cube
        write_cube(5, 1'b0, 2'b00, 14'h0, 14'h0);
        write_cube(0, 1'b1, 2'b01, 14'h0000, 14'h0000);
        write_cube(15, 1'b1, 2'b10, 14'h0001, 14'h0001);
        for (int i = 0; i < 2; i++) begin
            model(vb[i].x, ey, lat);
            eval_vec(vb[i].x, vb[i].y, lat, 1'b0, $sformatf("vecB%0d", i));
        end

        // backpressure in DONE, with a table write that must be ignored
        in_valid = 1'b1;
        x        = 14'h0001;
        step();
        in_valid = 1'b0;
        cnt = 0;
        while (!out_valid && cnt < 40) begin
            step();
            cnt++;
        end
        chk("bp latency", 32'(cnt), 32'(N_CUBES));
        for (int i = 0; i < 10; i++) begin
            chk("bp y stable", 32'(y), 32'd3);
            chk("bp out_valid", 32'(out_valid), 32'd1);
            chk("bp in_ready", 32'(in_ready), 32'd0);
            if (i == 4) begin
                cfg_we   = 1'b1;
                cfg_addr = 4'd0;
                cfg_data = {1'b1, 2'b10, 14'h0, 14'h0};
            end else begin
                cfg_we = 1'b0;
            end
            step();
        end
        cfg_we    = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("bp release", 32'(out_valid), 32'd0);
        eval_vec(14'h0000, 2'b01, N_CUBES, 1'b0, "old cube0");

        // write and vector in the same IDLE cycle
        cfg_we   = 1'b1;
        cfg_addr = 4'd3;
        cfg_data = {1'b1, 2'b10, 14'h3FFF, 14'h0000};
        in_valid = 1'b1;
        x        = 14'h0000;
        #1;
        chk("collide in_ready", 32'(in_ready), 32'd0);
        chk("collide cfg_ready", 32'(cfg_ready), 32'd1);
        step();
        cfg_we = 1'b0;
        mdl[3] = '{1'b1, 2'b10, 14'h3FFF, 14'h0000};
        chk("collide not accepted", 32'(cfg_ready), 32'd1);
        eval_vec(14'h0000, 2'b11, N_CUBES, 1'b0, "collide new cube");

        // randomized cubes and vectors against the model
        for (int it = 0; it < 24; it++) begin
            int a;
            logic [13:0] xv;
            a = $urandom_range(0, N_CUBES - 1);
            write_cube(a, ($urandom_range(0, 3) != 0), 2'($urandom),
                       14'($urandom & $urandom & $urandom), 14'($urandom));
            if ($urandom_range(0, 1) == 1)
                xv = mdl[$urandom_range(0, N_CUBES - 1)].val ^ 14'($urandom & $urandom & $urandom);
            else
                xv = 14'($urandom);
            eval_model(xv, 1'($urandom), $sformatf("rand%0d", it));
        end

        // reset in the middle of a scan
        write_cube(0, 1'b1, 2'b01, 14'h0, 14'h0);
        eval_model(14'h0000, 1'b0, "pre-abort");
        in_valid = 1'b1;
        x        = 14'h0000;
        step();
        in_valid = 1'b0;
        repeat (7) step();
        chk("abort in EVAL", 32'(cfg_ready), 32'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < N_CUBES; i++) mdl[i].en = 1'b0;
        chk("abort out_valid", 32'(out_valid), 32'd0);
        chk("abort y", 32'(y), 32'd0);
        chk("abort cfg_ready", 32'(cfg_ready), 32'd1);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (out_valid) seen = 1'b1;
            step();
        end
        chk("abort no result", 32'(seen), 32'd0);
        eval_model(14'h3FFF, 1'b0, "abort table empty");
        eval_model(14'h0000, 1'b1, "abort table empty 2");

        // full mask from cube 0: one clock with early exit, full scan without
        write_cube(0, 1'b1, 2'b11, 14'h0, 14'h0);
        model(14'h1234, ey, lat);
        chk("early y model", 32'(ey), 32'd3);
`ifdef PLA_EARLY_EXIT_EN
        chk("early lat model", 32'(lat), 32'd1);
`else
        chk("early lat model", 32'(lat), 32'(N_CUBES));
`endif
        eval_vec(14'h1234, 2'b11, lat, 1'b0, "early");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
